// File: rtl/hub75_frame_buffer.sv
// Double-buffered 64x32 HUB75 pixel store: back-bank writes and clears, front-bank
// column reads, and buffer swaps deferred to the scan driver's end-of-frame pulse.
//
// state     | meaning
// IDLE      | writes and requests accepted (ready=1)
// CLEAR     | zeroing back bank, one address of TOP and BOT per cycle
// SWAP_WAIT | swap requested, waiting for frame_end to toggle front_sel
module hub75_frame_buffer #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 32,
  parameter int COLOR_BITS = 3,
  localparam int CW = $clog2(WIDTH),
  localparam int RW = $clog2(HEIGHT / 2)
) (
  input  logic                  clk_27MHz,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_x,
  input  logic [RW:0]           wr_y,
  input  logic [COLOR_BITS-1:0] wr_rgb,
  input  logic                  clear_req,
  input  logic                  swap_req,
  output logic                  ready,
  output logic                  swap_done,
  output logic                  front_sel,
  input  logic                  frame_end,
  input  logic                  rd_en,
  input  logic [CW-1:0]         rd_col,
  input  logic [RW-1:0]         rd_row,
  output logic                  rd_valid,
  output logic [COLOR_BITS-1:0] rgb1,
  output logic [COLOR_BITS-1:0] rgb2
);

  localparam int AW    = 1 + RW + CW;
  localparam int DEPTH = 2 ** AW;
  localparam logic [RW+CW-1:0] CLR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [COLOR_BITS-1:0] mem_top [DEPTH];
  logic [COLOR_BITS-1:0] mem_bot [DEPTH];

  logic [RW+CW-1:0]      clr_cnt;
  logic                  clearing;
  logic                  swap_fire;
  logic                  pix_wr;
  logic                  top_we;
  logic                  bot_we;
  logic [AW-1:0]         wr_addr;
  logic [COLOR_BITS-1:0] wr_data;
  logic [AW-1:0]         rd_addr;

  // FSM state register
  always_ff @(posedge clk_27MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; clear wins over a simultaneous swap request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_req)     state_nxt = CLEAR;
        else if (swap_req) state_nxt = SWAP_WAIT;
      end
      CLEAR:     if (clr_cnt == CLR_LAST) state_nxt = IDLE;
      SWAP_WAIT: if (frame_end)           state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready     = (state == IDLE);
    clearing  = !rst && (state == CLEAR);
    swap_fire = !rst && (state == SWAP_WAIT) && frame_end;
    swap_done = swap_fire;
  end

  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      clr_cnt   <= '0;
      front_sel <= 1'b0;
    end else begin
      if (state == IDLE && clear_req) clr_cnt <= '0;
      else if (clearing)              clr_cnt <= clr_cnt + 1'b1;
      if (swap_fire) front_sel <= ~front_sel;
    end
  end

  // Shared write port: the clear engine owns it while clearing, else the pixel source
  always_comb begin
    pix_wr  = !rst && ready && wr_en;
    top_we  = clearing || (pix_wr && !wr_y[RW]);
    bot_we  = clearing || (pix_wr &&  wr_y[RW]);
    wr_addr = clearing ? {~front_sel, clr_cnt} : {~front_sel, wr_y[RW-1:0], wr_x};
    wr_data = clearing ? '0 : wr_rgb;
    rd_addr = {front_sel, rd_row, rd_col};
  end

  always_ff @(posedge clk_27MHz) begin
    if (top_we) mem_top[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_27MHz) begin
    if (bot_we) mem_bot[wr_addr] <= wr_data;
  end

  // Reads use the registered front_sel, so a read in the toggle cycle sees the old bank
  always_ff @(posedge clk_27MHz) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rgb1     <= '0;
      rgb2     <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rgb1 <= mem_top[rd_addr];
        rgb2 <= mem_bot[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Self-checking bench for hub75_frame_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a pixel-array reference model.
module tb_hub75_frame_buffer;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int CB = 3;
  localparam int CW = 6;
  localparam int RW = 4;

  logic          clk_27MHz = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_x = '0;
  logic [RW:0]   wr_y = '0;
  logic [CB-1:0] wr_rgb = '0;
  logic          clear_req = 1'b0;
  logic          swap_req = 1'b0;
  logic          ready;
  logic          swap_done;
  logic          front_sel;
  logic          frame_end = 1'b0;
  logic          rd_en = 1'b0;
  logic [CW-1:0] rd_col = '0;
  logic [RW-1:0] rd_row = '0;
  logic          rd_valid;
  logic [CB-1:0] rgb1;
  logic [CB-1:0] rgb2;

  hub75_frame_buffer dut (
    .clk_27MHz (clk_27MHz),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_rgb    (wr_rgb),
    .clear_req (clear_req),
    .swap_req  (swap_req),
    .ready     (ready),
    .swap_done (swap_done),
    .front_sel (front_sel),
    .frame_end (frame_end),
    .rd_en     (rd_en),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_valid  (rd_valid),
    .rgb1      (rgb1),
    .rgb2      (rgb2)
  );

  always #5 clk_27MHz = ~clk_27MHz;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: whole-frame pixel arrays per bank, busy time as a cycle count
  logic [CB-1:0] m_mem [2][H][W];
  bit            m_front;
  int            m_clear_left;
  bit            m_pending;
  logic [CB-1:0] m_rgb1;
  logic [CB-1:0] m_rgb2;
  bit            m_rvalid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_front      = 1'b0;
    m_clear_left = 0;
    m_pending    = 1'b0;
    m_rgb1       = '0;
    m_rgb2       = '0;
    m_rvalid     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; clear_req = 1'b0; swap_req = 1'b0; frame_end = 1'b0; rd_en = 1'b0;
    @(posedge clk_27MHz);
    @(negedge clk_27MHz);
    rst = 1'b0;
    model_reset();
    check("rst_ready", ready, 1);
    check("rst_front_sel", front_sel, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_rgb1", rgb1, 0);
    check("rst_rgb2", rgb2, 0);
  endtask

  // One clock cycle: drive inputs at negedge, check, advance model, check registered outputs
  task automatic step(input bit we, input logic [CW-1:0] x, input logic [RW:0] y,
                      input logic [CB-1:0] rgb, input bit clr, input bit swp, input bit fe,
                      input bit re, input logic [CW-1:0] rc, input logic [RW-1:0] rr);
    bit ready_now;
    bit exp_swap;
    wr_en = we; wr_x = x; wr_y = y; wr_rgb = rgb;
    clear_req = clr; swap_req = swp; frame_end = fe;
    rd_en = re; rd_col = rc; rd_row = rr;
    #1;
    ready_now = (m_clear_left == 0) && !m_pending;
    exp_swap  = m_pending && fe;
    check("ready", ready, ready_now);
    check("swap_done", swap_done, exp_swap);
    m_rvalid = re;
    if (re) begin
      m_rgb1 = m_mem[m_front][rr][rc];
      m_rgb2 = m_mem[m_front][rr + H/2][rc];
    end
    if (ready_now) begin
      if (we) m_mem[!m_front][y][x] = rgb;
      if (clr) begin
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            m_mem[!m_front][r][c] = '0;
        m_clear_left = W * H / 2;
      end else if (swp) begin
        m_pending = 1'b1;
      end
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (m_pending && fe) begin
      m_front   = !m_front;
      m_pending = 1'b0;
    end
    @(posedge clk_27MHz);
    @(negedge clk_27MHz);
    check("front_sel", front_sel, m_front);
    check("rd_valid", rd_valid, m_rvalid);
    check("rgb1", rgb1, m_rgb1);
    check("rgb2", rgb2, m_rgb2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [CW-1:0] x, input logic [RW:0] y, input logic [CB-1:0] rgb);
    step(1, x, y, rgb, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [CW-1:0] c, input logic [RW-1:0] r, input bit fe);
    step(0, 0, 0, 0, 0, 0, fe, 1, c, r);
  endtask

  task automatic swap_now(input int gap);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(gap);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic full_clear();
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(W * H / 2);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          m_mem[b][r][c] = '0;
    model_reset();
    @(negedge clk_27MHz);
    do_reset();

    // Clear both banks; back reads after the swap are zero
    full_clear();
    check("clear_done_ready", ready, 1);
    swap_now(3);
    check("swap1_front", front_sel, 1);
    full_clear();
    rd(0, 0, 0);
    check("cleared_rgb1", rgb1, 0);
    rd(63, 15, 0);
    check("cleared_rgb2", rgb2, 0);
    swap_now(2);

    // Top/bottom write then deferred swap
    wr(3, 5, 3'b101);
    wr(3, 21, 3'b011);
    swap_now(9);
    check("t2_front", front_sel, 1);
    rd(3, 5, 0);
    check("t2_rgb1", rgb1, 3'b101);
    check("t2_rgb2", rgb2, 3'b011);

    // Long swap wait; writes during the wait are dropped
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) step(1, 7, 7, 3'b111, 0, 0, 0, 0, 0, 0);
    check("t3_front_held", front_sel, 1);
    check("t3_ready_low", ready, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    rd(7, 7, 0);
    check("t3_write_dropped", rgb1, 0);

    // Clear and swap together: clear only, later frame_end does nothing
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(W * H / 2);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("t4_front_unchanged", front_sel, 0);

    // Front reads keep the old value until the swap, including the toggle cycle
    wr(10, 2, 3'b110);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) rd(10, 2, 0);
    check("t5_before_swap", rgb1, 0);
    rd(10, 2, 1);
    check("t5_toggle_cycle", rgb1, 0);
    rd(10, 2, 0);
    check("t5_after_swap", rgb1, 3'b110);

    // Reset in the middle of a clear
    swap_now(1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(298);
    rd(1, 1, 0);
    do_reset();
    full_clear();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), CW'($urandom), (RW + 1)'($urandom), CB'($urandom),
           $urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1),
           CW'($urandom), RW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
